// File: rtl/shift_ring_pkg.sv
// Shared constants and seed helper for the shift/ring counter.
// Optional self-correction is enabled by defining SHIFT_RING_SELF_CORRECT_EN.
package shift_ring_pkg;

   localparam logic MODE_JOHNSON = 1'b0;
   localparam logic MODE_RING    = 1'b1;
   localparam logic DIR_UP       = 1'b0;
   localparam logic DIR_DOWN     = 1'b1;

   // Seed is all zeros for Johnson and bit 0 set for ring, masked to width.
   function automatic logic [31:0] seed_value(input logic mode, input int unsigned width);
      logic [31:0] mask;
      mask = 32'hFFFF_FFFF >> (32 - width);
      return (mode == MODE_RING) ? (32'd1 & mask) : 32'd0;
   endfunction

endpackage

// File: rtl/shift_ring_phase_dec.sv
// Combinational legality check and phase index decode for the counter state.
module shift_ring_phase_dec
   import shift_ring_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int IDXW  = $clog2(2*WIDTH)
) (
   input  logic [WIDTH-1:0] count,
   input  logic             mode,
   output logic [IDXW-1:0]  phase,
   output logic             illegal
);

   logic [WIDTH-1:0] inv;
   logic [WIDTH-1:0] cnt_p1;
   logic [WIDTH-1:0] inv_p1;
   logic             low_therm;
   logic             high_therm;
   int               ones;
   int               ring_idx;

   // Johnson states are either a run of ones from the LSB or a run of ones from the MSB.
   assign inv        = ~count;
   assign cnt_p1     = count + {{(WIDTH-1){1'b0}}, 1'b1};
   assign inv_p1     = inv + {{(WIDTH-1){1'b0}}, 1'b1};
   assign low_therm  = ((count & cnt_p1) == '0);
   assign high_therm = ((inv & inv_p1) == '0);

   always_comb begin
      ones     = 0;
      ring_idx = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (count[i]) begin
            ones     = ones + 1;
            ring_idx = i;
         end
      end
   end

   always_comb begin
      illegal = 1'b0;
      phase   = '0;
      if (mode == MODE_RING) begin
         illegal = (ones != 1);
         if (!illegal) phase = IDXW'(ring_idx);
      end else begin
         illegal = !(low_therm || high_therm);
         if (!illegal) phase = count[WIDTH-1] ? IDXW'(2*WIDTH - ones) : IDXW'(ones);
      end
   end

endmodule

// File: rtl/shift_ring_counter.sv
// Johnson / one-hot ring counter with load, direction, wrap pulse and phase decode.
// Define SHIFT_RING_SELF_CORRECT_EN to reseed from illegal states on an enabled cycle.
module shift_ring_counter
   import shift_ring_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int IDXW  = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic [IDXW-1:0]  phase,
   output logic             wrap,
   output logic             illegal
);

`ifdef SHIFT_RING_SELF_CORRECT_EN
   localparam bit SELF_CORRECT = 1'b1;
`else
   localparam bit SELF_CORRECT = 1'b0;
`endif

   logic             mode_q;
   logic [WIDTH-1:0] seed;
   logic [WIDTH-1:0] step_val;

   assign seed = WIDTH'(seed_value(mode, WIDTH));

   always_comb begin
      step_val = count;
      case ({mode, dir})
         {MODE_JOHNSON, DIR_UP}:   step_val = {count[WIDTH-2:0], ~count[WIDTH-1]};
         {MODE_JOHNSON, DIR_DOWN}: step_val = {~count[0], count[WIDTH-1:1]};
         {MODE_RING, DIR_UP}:      step_val = {count[WIDTH-2:0], count[WIDTH-1]};
         default:                  step_val = {count[0], count[WIDTH-1:1]};
      endcase
   end

   shift_ring_phase_dec #(.WIDTH(WIDTH), .IDXW(IDXW)) u_dec (
      .count   (count),
      .mode    (mode),
      .phase   (phase),
      .illegal (illegal)
   );

   // Priority: load, mode change, self-correction, step, hold. Only a real step may pulse wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count  <= '0;
         wrap   <= 1'b0;
         mode_q <= MODE_JOHNSON;
      end else begin
         mode_q <= mode;
         wrap   <= 1'b0;
         if (load) begin
            count <= load_val;
         end else if (mode != mode_q) begin
            count <= seed;
         end else if (SELF_CORRECT && en && illegal) begin
            count <= seed;
         end else if (en) begin
            count <= step_val;
            wrap  <= (step_val == seed);
         end
      end
   end

endmodule

// File: tb/tb_shift_ring_counter.sv
// Bench for shift_ring_counter (WIDTH=5): directed vector table plus randomized model comparison.
module tb_shift_ring_counter;

   localparam int W   = 5;
   localparam int IW  = $clog2(2*W);

   logic          clk;
   logic          reset;
   logic          en;
   logic          mode;
   logic          dir;
   logic          load;
   logic [W-1:0]  load_val;
   logic [W-1:0]  count;
   logic [IW-1:0] phase;
   logic          wrap;
   logic          illegal;

   int n_checks = 0;
   int n_pass   = 0;

   logic [W-1:0] exp_q[$];

   logic [W-1:0] m_count;
   logic         m_wrap;
   logic         m_mode_q;

   typedef struct {
      logic          en;
      logic          mode;
      logic          dir;
      logic          load;
      logic [W-1:0]  lv;
      logic [W-1:0]  e_count;
      logic          e_wrap;
      logic [IW-1:0] e_phase;
      logic          e_ill;
   } vec_t;

   vec_t vecs[$];

   shift_ring_counter #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .mode     (mode),
      .dir      (dir),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .phase    (phase),
      .wrap     (wrap),
      .illegal  (illegal)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // reference model: legal states are enumerated by sequence index
   function automatic logic [W-1:0] j_pat(input int k);
      if (k <= W) return W'((1 << k) - 1);
      return W'(((1 << W) - 1) & ~((1 << (k - W)) - 1));
   endfunction

   function automatic logic [W-1:0] pat(input logic m, input int k);
      return m ? W'(1 << k) : j_pat(k);
   endfunction

   function automatic int model_index(input logic m, input logic [W-1:0] c);
      int n;
      n = m ? W : 2*W;
      for (int k = 0; k < n; k++) if (pat(m, k) == c) return k;
      return -1;
   endfunction

   function automatic logic [W-1:0] raw_shift(input logic m, input logic d, input logic [W-1:0] c);
      int v, msb, lsb, fill;
      v   = int'(c);
      msb = (v >> (W-1)) & 1;
      lsb = v & 1;
      if (!d) begin
         fill = m ? msb : 1 - msb;
         return W'(((v * 2) % (1 << W)) + fill);
      end
      fill = m ? lsb : 1 - lsb;
      return W'((v / 2) + fill * (1 << (W-1)));
   endfunction

   task automatic model_step(input logic en_i, input logic mode_i, input logic dir_i,
                             input logic load_i, input logic [W-1:0] lv);
      logic [W-1:0] seed;
      int idx, n;
      seed   = mode_i ? W'(1) : W'(0);
      n      = mode_i ? W : 2*W;
      m_wrap = 1'b0;
      if (load_i) begin
         m_count = lv;
      end else if (mode_i != m_mode_q) begin
         m_count = seed;
      end else if (en_i) begin
         idx = model_index(mode_i, m_count);
         if (idx >= 0) begin
            idx     = dir_i ? (idx + n - 1) % n : (idx + 1) % n;
            m_count = pat(mode_i, idx);
            m_wrap  = (idx == 0);
         end else begin
`ifdef SHIFT_RING_SELF_CORRECT_EN
            m_count = seed;
`else
            m_count = raw_shift(mode_i, dir_i, m_count);
            m_wrap  = (m_count == seed);
`endif
         end
      end
      m_mode_q = mode_i;
   endtask

   task automatic model_reset();
      m_count  = '0;
      m_wrap   = 1'b0;
      m_mode_q = 1'b0;
   endtask

   // driver: apply inputs, advance one edge, compare against the model
   task automatic drive_cycle(input logic en_i, input logic mode_i, input logic dir_i,
                              input logic load_i, input logic [W-1:0] lv);
      logic [W-1:0] exp_c;
      int idx;
      en = en_i; mode = mode_i; dir = dir_i; load = load_i; load_val = lv;
      model_step(en_i, mode_i, dir_i, load_i, lv);
      exp_q.push_back(m_count);
      @(posedge clk);
      #1;
      exp_c = exp_q.pop_front();
      idx   = model_index(mode, exp_c);
      chk("model_count", 32'(count), 32'(exp_c));
      chk("model_wrap", 32'(wrap), 32'(m_wrap));
      chk("model_illegal", 32'(illegal), (idx < 0) ? 32'd1 : 32'd0);
      chk("model_phase", 32'(phase), (idx < 0) ? 32'd0 : 32'(idx));
   endtask

   function automatic void add(input logic e, input logic m, input logic d, input logic l,
                               input logic [W-1:0] lv, input logic [W-1:0] ec,
                               input logic ew, input logic [IW-1:0] ep, input logic ei);
      vec_t v;
      v.en = e; v.mode = m; v.dir = d; v.load = l; v.lv = lv;
      v.e_count = ec; v.e_wrap = ew; v.e_phase = ep; v.e_ill = ei;
      vecs.push_back(v);
   endfunction

   initial begin
      reset = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
      model_reset();

      // Johnson up, full lap
      add(1,0,0,0,5'b00000, 5'b00001,0,4'd1,0);
      add(1,0,0,0,5'b00000, 5'b00011,0,4'd2,0);
      add(1,0,0,0,5'b00000, 5'b00111,0,4'd3,0);
      add(1,0,0,0,5'b00000, 5'b01111,0,4'd4,0);
      add(1,0,0,0,5'b00000, 5'b11111,0,4'd5,0);
      add(1,0,0,0,5'b00000, 5'b11110,0,4'd6,0);
      add(1,0,0,0,5'b00000, 5'b11100,0,4'd7,0);
      add(1,0,0,0,5'b00000, 5'b11000,0,4'd8,0);
      add(1,0,0,0,5'b00000, 5'b10000,0,4'd9,0);
      add(1,0,0,0,5'b00000, 5'b00000,1,4'd0,0);
      // Johnson down then reversal
      add(1,0,1,0,5'b00000, 5'b10000,0,4'd9,0);
      add(1,0,1,0,5'b00000, 5'b11000,0,4'd8,0);
      add(1,0,0,0,5'b00000, 5'b10000,0,4'd9,0);
      add(1,0,0,0,5'b00000, 5'b00000,1,4'd0,0);
      // reach 00111, switch to ring with en low, then ring lap
      add(1,0,0,0,5'b00000, 5'b00001,0,4'd1,0);
      add(1,0,0,0,5'b00000, 5'b00011,0,4'd2,0);
      add(1,0,0,0,5'b00000, 5'b00111,0,4'd3,0);
      add(0,1,0,0,5'b00000, 5'b00001,0,4'd0,0);
      add(1,1,0,0,5'b00000, 5'b00010,0,4'd1,0);
      add(1,1,0,0,5'b00000, 5'b00100,0,4'd2,0);
      add(1,1,0,0,5'b00000, 5'b01000,0,4'd3,0);
      add(1,1,0,0,5'b00000, 5'b10000,0,4'd4,0);
      add(1,1,0,0,5'b00000, 5'b00001,1,4'd0,0);
      // load of an illegal Johnson pattern (with simultaneous mode change), then one step
      add(1,0,0,1,5'b00101, 5'b00101,0,4'd0,1);
`ifdef SHIFT_RING_SELF_CORRECT_EN
      add(1,0,0,0,5'b00000, 5'b00000,0,4'd0,0);
`else
      add(1,0,0,0,5'b00000, 5'b01011,0,4'd0,1);
`endif
      // load beats mode change, then hold for 8 cycles
      add(0,1,0,1,5'b00100, 5'b00100,0,4'd2,0);
      for (int i = 0; i < 8; i++) add(0,1,i[0],0,5'b11111, 5'b00100,0,4'd2,0);

      // reset state
      @(posedge clk);
      #1;
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_wrap", 32'(wrap), 32'd0);
      chk("reset_phase", 32'(phase), 32'd0);
      chk("reset_illegal", 32'(illegal), 32'd0);
      reset = 1'b1;

      foreach (vecs[i]) begin
         drive_cycle(vecs[i].en, vecs[i].mode, vecs[i].dir, vecs[i].load, vecs[i].lv);
         chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
         chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].e_wrap));
         chk($sformatf("vec%0d_phase", i), 32'(phase), 32'(vecs[i].e_phase));
         chk($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vecs[i].e_ill));
      end

      // asynchronous reset mid-run from 01111
      drive_cycle(0, 0, 0, 1, 5'b01111);
      drive_cycle(1, 0, 0, 0, 5'b00000);
      chk("pre_reset_count", 32'(count), 32'b11111);
      drive_cycle(1, 0, 1, 0, 5'b00000);
      chk("pre_reset_count2", 32'(count), 32'b01111);
      #3;
      reset = 1'b0;
      mode  = 1'b1;
      #1;
      chk("async_reset_count", 32'(count), 32'd0);
      chk("async_reset_wrap", 32'(wrap), 32'd0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      // release with ring mode selected seeds the ring on the first edge
      drive_cycle(0, 1, 0, 0, 5'b00000);
      chk("release_ring_seed", 32'(count), 32'b00001);
      chk("release_wrap", 32'(wrap), 32'd0);

      // randomized stimulus against the model
      for (int i = 0; i < 600; i++) begin
         logic r_en, r_mode, r_dir, r_load;
         logic [W-1:0] r_lv;
         r_en   = ($urandom_range(0, 3) != 0);
         r_mode = ($urandom_range(0, 15) == 0) ? ~mode : mode;
         r_dir  = ($urandom_range(0, 5) == 0) ? ~dir : dir;
         r_load = ($urandom_range(0, 15) == 0);
         r_lv   = W'($urandom_range(0, (1 << W) - 1));
         drive_cycle(r_en, r_mode, r_dir, r_load, r_lv);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
